// File: rtl/fpu_multiply_iterative_pkg.sv
// Types and helpers for the iterative single-precision multiplier: float fields,
// special-value conditions, unrounded result, FSM state and working registers.
package fpu_multiply_iterative_pkg;

  typedef logic [2:0] fpu_round_mode_t;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_NORM, ST_DONE} fpu_mul_state_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } fpu_float_t;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fpu_cond_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [23:0] mantissa;
    logic [2:0]  guard;
    fpu_cond_t   cond;
  } fpu_result_t;

  typedef struct packed {
    logic              sign;
    logic signed [9:0] exponent;
    fpu_cond_t         cond;
  } fpu_mul_exp_t;

  typedef struct packed {
    logic              sign;
    logic [47:0]       product;
    logic signed [9:0] exponent;
    fpu_cond_t         cond;
    fpu_round_mode_t   mode;
    logic [4:0]        count;
  } fpu_mul_work_t;

  // Denormals flush to zero, so any zero exponent counts as zero.
  function automatic fpu_cond_t fpu_float_classify(fpu_float_t f);
    fpu_cond_t c;
    c.zero = (f.exponent == 8'd0);
    c.inf  = (f.exponent == 8'hFF) && (f.mantissa == 23'd0);
    c.nan  = (f.exponent == 8'hFF) && (f.mantissa != 23'd0);
    return c;
  endfunction

  function automatic fpu_mul_exp_t fpu_float_mul_exponent(fpu_float_t a, fpu_float_t b);
    fpu_mul_exp_t r;
    fpu_cond_t    ca;
    fpu_cond_t    cb;
    ca = fpu_float_classify(a);
    cb = fpu_float_classify(b);
    r.sign      = a.sign ^ b.sign;
    r.exponent  = $signed({2'b00, a.exponent}) + $signed({2'b00, b.exponent}) - 10'sd127;
    r.cond.nan  = ca.nan | cb.nan | (ca.inf & cb.zero) | (ca.zero & cb.inf);
    r.cond.inf  = ca.inf | cb.inf;
    r.cond.zero = ca.zero | cb.zero;
    return r;
  endfunction

  // Flags resolve nan > inf > zero; forced results carry no mantissa bits.
  function automatic fpu_result_t fpu_float_mul_normalize(fpu_mul_work_t w);
    fpu_result_t       r;
    logic signed [9:0] e;
    logic [23:0]       m;
    logic [2:0]        g;
    if (w.product[47]) begin
      e = w.exponent + 10'sd1;
      m = w.product[47:24];
      g = {w.product[23:22], |w.product[21:0]};
    end else begin
      e = w.exponent;
      m = w.product[46:23];
      g = {w.product[22:21], |w.product[20:0]};
    end
    r      = '0;
    r.sign = w.sign;
    if (w.cond.nan) begin
      r.cond.nan = 1'b1;
      r.exponent = 8'hFF;
    end else if (w.cond.inf || e >= 10'sd255) begin
      r.cond.inf = 1'b1;
      r.exponent = 8'hFF;
    end else if (w.cond.zero || e <= 10'sd0) begin
      r.cond.zero = 1'b1;
    end else begin
      r.exponent = e[7:0];
      r.mantissa = m;
      r.guard    = g;
    end
    return r;
  endfunction

endpackage

// File: rtl/fpu_multiply_iterative_if.sv
// Operand and result valid/ready channels of the iterative multiplier.
interface fpu_multiply_iterative_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [2:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [7:0]  out_exponent;
  logic [23:0] out_mantissa;
  logic [2:0]  out_guard;
  logic        out_nan;
  logic        out_inf;
  logic        out_zero;
  logic [2:0]  out_mode;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_sign, out_exponent, out_mantissa,
           out_guard, out_nan, out_inf, out_zero, out_mode
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_sign, out_exponent, out_mantissa,
           out_guard, out_nan, out_inf, out_zero, out_mode
  );
endinterface

// File: rtl/fpu_multiply_iterative_step.sv
// One shift-add iteration: accumulates mcand times the low RADIX_BITS of mplier,
// then advances both operands by RADIX_BITS.
module fpu_mul_step #(
  parameter int RADIX_BITS = 1
) (
  input  logic [47:0] acc,
  input  logic [47:0] mcand,
  input  logic [23:0] mplier,
  output logic [47:0] acc_next,
  output logic [47:0] mcand_next,
  output logic [23:0] mplier_next
);
  logic [47:0] pp [RADIX_BITS];
  logic [47:0] pp_sum;

  for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_pp
    assign pp[gi] = mplier[gi] ? (mcand << gi) : 48'd0;
  end

  always_comb begin
    pp_sum = 48'd0;
    for (int i = 0; i < RADIX_BITS; i++) pp_sum = pp_sum + pp[i];
  end

  assign acc_next    = acc + pp_sum;
  assign mcand_next  = mcand << RADIX_BITS;
  assign mplier_next = mplier >> RADIX_BITS;
endmodule

// File: rtl/fpu_multiply_iterative.sv
// Iterative single-precision multiplier producing unrounded mantissa + GRS bits.
// Define FPU_MUL_EARLY_OUT_EN to skip the MUL phase for nan/inf/zero operands.
module fpu_multiply_iterative
  import fpu_multiply_iterative_pkg::*;
#(
  parameter int RADIX_BITS = 1
) (
  input logic                     clk,
  input logic                     rst_n,
  fpu_multiply_iterative_if.slave bus
);
  localparam int         ITERS = 24 / RADIX_BITS;
  localparam logic [4:0] LAST  = 5'(ITERS - 1);

  fpu_mul_state_t state_reg, state_next;
  fpu_mul_work_t  work_reg;
  fpu_result_t    result_reg;
  logic [47:0]    mcand_reg;
  logic [23:0]    mplier_reg;
  logic [47:0]    acc_next, mcand_next;
  logic [23:0]    mplier_next;
  fpu_float_t     a_f, b_f;
  fpu_mul_exp_t   cap;
  logic           early_out;

  assign a_f = bus.in_a;
  assign b_f = bus.in_b;
  assign cap = fpu_float_mul_exponent(a_f, b_f);

`ifdef FPU_MUL_EARLY_OUT_EN
  assign early_out = |cap.cond;
`else
  assign early_out = 1'b0;
`endif

  fpu_mul_step #(.RADIX_BITS(RADIX_BITS)) u_step (
    .acc         (work_reg.product),
    .mcand       (mcand_reg),
    .mplier      (mplier_reg),
    .acc_next    (acc_next),
    .mcand_next  (mcand_next),
    .mplier_next (mplier_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.in_valid) state_next = early_out ? ST_NORM : ST_MUL;
      ST_MUL:  if (work_reg.count == LAST) state_next = ST_NORM;
      ST_NORM: state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_reg == ST_IDLE);
    bus.out_valid = (state_reg == ST_DONE);
  end

  // Multiplicand walks left and multiplier walks right, so each step sees its bits at [0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_reg   <= '0;
      result_reg <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.in_valid) begin
          work_reg.sign     <= cap.sign;
          work_reg.product  <= 48'd0;
          work_reg.exponent <= cap.exponent;
          work_reg.cond     <= cap.cond;
          work_reg.mode     <= bus.in_mode;
          work_reg.count    <= 5'd0;
          mcand_reg         <= {24'd0, 1'b1, a_f.mantissa};
          mplier_reg        <= {1'b1, b_f.mantissa};
        end
        ST_MUL: begin
          work_reg.product <= acc_next;
          work_reg.count   <= work_reg.count + 5'd1;
          mcand_reg        <= mcand_next;
          mplier_reg       <= mplier_next;
        end
        ST_NORM: result_reg <= fpu_float_mul_normalize(work_reg);
        default: ;
      endcase
    end
  end

  assign bus.out_sign     = result_reg.sign;
  assign bus.out_exponent = result_reg.exponent;
  assign bus.out_mantissa = result_reg.mantissa;
  assign bus.out_guard    = result_reg.guard;
  assign bus.out_nan      = result_reg.cond.nan;
  assign bus.out_inf      = result_reg.cond.inf;
  assign bus.out_zero     = result_reg.cond.zero;
  assign bus.out_mode     = work_reg.mode;
endmodule

// File: tb/tb_fpu_multiply_iterative.sv
// Directed bench for fpu_multiply_iterative (RADIX_BITS=1); honours FPU_MUL_EARLY_OUT_EN.
module tb_fpu_multiply_iterative;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpu_multiply_iterative_if bus ();
  fpu_multiply_iterative #(.RADIX_BITS(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int passed = 0;
  int failed = 0;
  int cycles;
  logic seen_valid;

`ifdef FPU_MUL_EARLY_OUT_EN
  localparam int SPECIAL_LAT = 2;
`else
  localparam int SPECIAL_LAT = 26;
`endif

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] mode);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_mode  = mode;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
  endtask

  // Counts the handshake edge as cycle 1; gives up after 100 cycles.
  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1 n++;
    end
  endtask

  task automatic check_result(input string tag, input logic s, input logic [7:0] e,
                              input logic [23:0] m, input logic [2:0] g,
                              input logic n, input logic i, input logic z);
    chk({tag, ".sign"}, 40'(bus.out_sign), 40'(s));
    chk({tag, ".exp"},  40'(bus.out_exponent), 40'(e));
    chk({tag, ".mant"}, 40'(bus.out_mantissa), 40'(m));
    chk({tag, ".grd"},  40'(bus.out_guard), 40'(g));
    chk({tag, ".flags"}, 40'({bus.out_nan, bus.out_inf, bus.out_zero}), 40'({n, i, z}));
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    chk({tag, ".rdy_after"}, 40'(bus.in_ready), 40'(1));
    chk({tag, ".vld_after"}, 40'(bus.out_valid), 40'(0));
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_mode   = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("reset.vld", 40'(bus.out_valid), 40'(0));
    chk("reset.out", 40'({bus.out_sign, bus.out_exponent, bus.out_mantissa, bus.out_guard,
                          bus.out_nan, bus.out_inf, bus.out_zero}), 40'(0));
    chk("reset.mode", 40'(bus.out_mode), 40'(0));
    @(negedge clk) rst_n = 1'b1;
    #1 chk("reset.rdy", 40'(bus.in_ready), 40'(1));

    // 1.5 * 2.0 = 3.0
    start_op(32'h3FC00000, 32'h40000000, 3'd0);
    wait_valid(cycles);
    $display("op 3FC00000*40000000 latency=%0d exp=%h mant=%h", cycles, bus.out_exponent, bus.out_mantissa);
    chk("t1.lat", 40'(cycles), 40'(26));
    check_result("t1", 1'b0, 8'h80, 24'hC00000, 3'b000, 1'b0, 1'b0, 1'b0);
    finish_op("t1");

    // -2.0 * 3.0 = -6.0, mode carried through
    start_op(32'hC0000000, 32'h40400000, 3'd2);
    wait_valid(cycles);
    $display("op C0000000*40400000 sign=%b exp=%h mant=%h mode=%0d", bus.out_sign, bus.out_exponent, bus.out_mantissa, bus.out_mode);
    check_result("t2", 1'b1, 8'h81, 24'hC00000, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("t2.mode", 40'(bus.out_mode), 40'(2));
    finish_op("t2");

    // (1+2^-23)^2: sticky from the 2^-46 term
    start_op(32'h3F800001, 32'h3F800001, 3'd1);
    wait_valid(cycles);
    $display("op 3F800001*3F800001 exp=%h mant=%h grd=%b", bus.out_exponent, bus.out_mantissa, bus.out_guard);
    check_result("t3", 1'b0, 8'h7F, 24'h800002, 3'b001, 1'b0, 1'b0, 1'b0);
    finish_op("t3");

    // inf * 0 -> nan
    start_op(32'h7F800000, 32'h00000000, 3'd0);
    wait_valid(cycles);
    $display("op 7F800000*00000000 latency=%0d nan=%b", cycles, bus.out_nan);
    chk("t4.lat", 40'(cycles), 40'(SPECIAL_LAT));
    chk("t4.flags", 40'({bus.out_nan, bus.out_inf, bus.out_zero}), 40'(3'b100));
    finish_op("t4");

    // overflow -> inf
    start_op(32'h7F000000, 32'h7F000000, 3'd0);
    wait_valid(cycles);
    $display("op 7F000000*7F000000 inf=%b exp=%h", bus.out_inf, bus.out_exponent);
    check_result("t5", 1'b0, 8'hFF, 24'h000000, 3'b000, 1'b0, 1'b1, 1'b0);
    finish_op("t5");

    // underflow -> zero, then 5 cycles of backpressure
    start_op(32'h00800000, 32'h00800000, 3'd4);
    wait_valid(cycles);
    $display("op 00800000*00800000 zero=%b exp=%h", bus.out_zero, bus.out_exponent);
    check_result("t6", 1'b0, 8'h00, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp.vld", 40'(bus.out_valid), 40'(1));
      chk("bp.rdy", 40'(bus.in_ready), 40'(0));
      chk("bp.mode", 40'(bus.out_mode), 40'(4));
      check_result("bp", 1'b0, 8'h00, 24'h000000, 3'b000, 1'b0, 1'b0, 1'b1);
    end
    finish_op("bp");

    // reset pulse during the 10th MUL cycle discards the operation
    start_op(32'h3FC00000, 32'h40000000, 3'd0);
    repeat (9) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst.rdy", 40'(bus.in_ready), 40'(1));
    seen_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1 if (bus.out_valid) seen_valid = 1'b1;
    end
    $display("op aborted by reset, out_valid seen=%b", seen_valid);
    chk("rst.novld", 40'(seen_valid), 40'(0));
    chk("rst.rdy2", 40'(bus.in_ready), 40'(1));

    start_op(32'h3FC00000, 32'h40000000, 3'd3);
    wait_valid(cycles);
    $display("op 3FC00000*40000000 after reset latency=%0d exp=%h mant=%h", cycles, bus.out_exponent, bus.out_mantissa);
    chk("t7.lat", 40'(cycles), 40'(26));
    check_result("t7", 1'b0, 8'h80, 24'hC00000, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("t7.mode", 40'(bus.out_mode), 40'(3));
    finish_op("t7");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
